// File: rtl/wgt_pingpong_buf.sv
// Ping-pong weight buffer for a KxK PE array: the shadow bank fills row by row
// from a valid/ready stream while the active bank drives every PE in parallel.

module wgt_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              sel,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] bank0, bank1;

  // Writes always target the shadow bank, i.e. the one not selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (we) begin
      if (sel) bank0 <= din;
      else     bank1 <= din;
    end
  end

  assign dout = sel ? bank1 : bank0;
endmodule

module wgt_pingpong_buf #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32,
  parameter int K      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic [K*K*DATA_W-1:0]         wgt_out,
  output logic                          wgt_valid,
  output logic [$clog2(K+1)-1:0]        fill_cnt
);
  localparam int PE_NUM = K*K;
  localparam int CW     = $clog2(K+1);
  localparam logic [CW-1:0] LAST = CW'(K-1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          swap_ack_q, wgt_valid_q;
  logic          accept, swap_take;

  // clr dominates both a beat and a swap on the same edge.
  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid && in_ready && !clr;
  assign swap_take = swap_req && (state_q == FULL) && !clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (clr) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (swap_take) begin
      state_d = EMPTY;
      cnt_d   = '0;
      sel_d   = ~sel_q;
    end else if (accept) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? FULL : FILLING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      swap_ack_q  <= 1'b0;
      wgt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      swap_ack_q <= swap_take;
      if (swap_take) wgt_valid_q <= 1'b1;
    end
  end

  assign swap_ack  = swap_ack_q;
  assign wgt_valid = wgt_valid_q;
  assign fill_cnt  = cnt_q;

  // Lane n sits at row n/K, column n%K; column 0 takes the most significant weight.
  for (genvar n = 0; n < PE_NUM; n++) begin : g_lane
    localparam int ROW = n / K;
    localparam int COL = n % K;
    wgt_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (accept && (cnt_q == CW'(ROW))),
      .sel  (sel_q),
      .din  (in_data[(K-1-COL)*DATA_W +: DATA_W]),
      .dout (wgt_out[n*DATA_W +: DATA_W])
    );
  end

  if (WORD_W > K*DATA_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^in_data[WORD_W-1:K*DATA_W];
  end
endmodule

// File: tb/tb_wgt_pingpong_buf.sv
// Directed bench for wgt_pingpong_buf: expected kernels are queued at each swap
// request and checked by a monitor whenever swap_ack fires.

module tb_wgt_pingpong_buf;
  localparam int W = 72;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid, in_ready, swap_req, swap_ack, wgt_valid;
  logic [31:0]   in_data;
  logic [W-1:0]  wgt_out;
  logic [1:0]    fill_cnt;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] expq[$];

  wgt_pingpong_buf #(.DATA_W(8), .WORD_W(32), .K(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .swap_req(swap_req), .swap_ack(swap_ack), .wgt_out(wgt_out),
    .wgt_valid(wgt_valid), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [W-1:0] KA = 72'h090807060504030201;
  localparam logic [W-1:0] KB = 72'h0908070605047F80FF;
  localparam logic [W-1:0] KC = 72'h2019181716150C0B0A;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every ack must match the oldest queued kernel.
  always @(negedge clk) begin
    if (rst_n && swap_ack) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL ack_unexpected: wgt_out %0h with no swap pending", wgt_out);
      end else begin
        logic [W-1:0] e;
        e = expq.pop_front();
        if (wgt_out !== e || wgt_valid !== 1'b1) begin
          bad++;
          $display("FAIL ack_data: got %0h valid %0b expected %0h valid 1", wgt_out, wgt_valid, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; swap_req = 1'b0; in_data = '0;
    #12;
    chk("rst_wgt_out", wgt_out, '0);
    chk("rst_wgt_valid", W'(wgt_valid), W'(0));
    chk("rst_swap_ack", W'(swap_ack), W'(0));
    chk("rst_fill_cnt", W'(fill_cnt), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    tick();

    // Kernel A: three rows, then swap
    beat(32'h00010203); chk("a_fill1", W'(fill_cnt), W'(1));
    beat(32'h00040506); chk("a_fill2", W'(fill_cnt), W'(2));
    beat(32'h00070809); chk("a_fill3", W'(fill_cnt), W'(3));
    chk("a_full_ready", W'(in_ready), W'(0));
    chk("a_preswap_out", wgt_out, '0);
    expq.push_back(KA);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("a_out", wgt_out, KA);
    chk("a_ack", W'(swap_ack), W'(1));
    chk("a_cnt_after", W'(fill_cnt), W'(0));
    tick();
    chk("a_ack_drop", W'(swap_ack), W'(0));
    chk("a_ready_after", W'(in_ready), W'(1));

    // Kernel B (signed row 0, junk top byte); A must hold throughout
    beat(32'hAAFF807F); chk("b_hold1", wgt_out, KA);
    beat(32'h00040506); chk("b_hold2", wgt_out, KA);
    beat(32'h00070809); chk("b_hold3", wgt_out, KA);

    // Backpressure while FULL
    in_valid = 1'b1; in_data = 32'h000A0B0C;
    tick(); tick();
    chk("bp_ready", W'(in_ready), W'(0));
    chk("bp_cnt", W'(fill_cnt), W'(3));
    chk("bp_hold", wgt_out, KA);
    expq.push_back(KB);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("b_out", wgt_out, KB);
    chk("bp_cnt_swap", W'(fill_cnt), W'(0));
    tick(); in_valid = 1'b0;
    chk("bp_accepted", W'(fill_cnt), W'(1));
    chk("b_pe0", W'($signed(wgt_out[7:0]) == -1), W'(1));
    chk("b_pe1", W'($signed(wgt_out[15:8]) == -128), W'(1));
    chk("b_pe2", W'($signed(wgt_out[23:16]) == 127), W'(1));

    // Early swap request is ignored, then taken once FULL
    beat(32'h00151617); chk("c_fill2", W'(fill_cnt), W'(2));
    swap_req = 1'b1; tick();
    chk("early_noack", W'(swap_ack), W'(0));
    chk("early_hold", wgt_out, KB);
    expq.push_back(KC);
    beat(32'h00181920);
    chk("last_beat_noack", W'(swap_ack), W'(0));
    chk("last_beat_cnt", W'(fill_cnt), W'(3));
    chk("last_beat_hold", wgt_out, KB);
    tick(); swap_req = 1'b0;
    chk("c_out", wgt_out, KC);
    chk("c_cnt", W'(fill_cnt), W'(0));
    tick();

    // clr mid-fill beats a coincident beat and swap request
    beat(32'h00010101);
    beat(32'h00020202); chk("clr_pre", W'(fill_cnt), W'(2));
    clr = 1'b1; swap_req = 1'b1; in_valid = 1'b1; in_data = 32'h00030303;
    tick();
    clr = 1'b0; swap_req = 1'b0; in_valid = 1'b0;
    chk("clr_cnt", W'(fill_cnt), W'(0));
    chk("clr_ready", W'(in_ready), W'(1));
    chk("clr_hold", wgt_out, KC);
    chk("clr_valid", W'(wgt_valid), W'(1));

    // Asynchronous reset mid-fill
    beat(32'h00050505);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", wgt_out, '0);
    chk("arst_valid", W'(wgt_valid), W'(0));
    chk("arst_cnt", W'(fill_cnt), W'(0));
    chk("arst_ready", W'(in_ready), W'(1));
    #10 rst_n = 1'b1;
    tick(); tick();
    chk("pending_swaps", W'(expq.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
